// File: rtl/ahb_line_fifo_if.sv
// Bus bundle for ahb_line_fifo: AHB-Lite slave signals plus the line-command
// valid/ready stream toward the display engine.
`timescale 1ns/1ps
interface ahb_line_fifo_if #(
    parameter int COORD_W = 9
);
    logic               HSEL;
    logic [31:0]        HADDR;
    logic [31:0]        HWDATA;
    logic [2:0]         HSIZE;
    logic [1:0]         HTRANS;
    logic               HWRITE;
    logic               HREADY;
    logic [31:0]        HRDATA;
    logic               HREADYOUT;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
    logic [COORD_W-1:0] x2;
    logic [COORD_W-1:0] y2;
    logic               DataValid;
    logic               DataReady;

    modport slave (
        input  HSEL, HADDR, HWDATA, HSIZE, HTRANS, HWRITE, HREADY, DataReady,
        output HRDATA, HREADYOUT, x1, y1, x2, y2, DataValid
    );

    modport master (
        output HSEL, HADDR, HWDATA, HSIZE, HTRANS, HWRITE, HREADY, DataReady,
        input  HRDATA, HREADYOUT, x1, y1, x2, y2, DataValid
    );
endinterface

// File: rtl/ahb_line_fifo.sv
// AHB-Lite slave queuing line-draw commands (x1,y1,x2,y2) in a DEPTH-entry FIFO
// and presenting the head entry on a valid/ready stream.
`timescale 1ns/1ps
module ahb_line_fifo #(
    parameter int COORD_W = 9,
    parameter int DEPTH   = 8
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    ahb_line_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int LW = 4 * COORD_W;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic               dp_vld_q, dp_vld_d;
    logic               dp_wr_q, dp_wr_d;
    logic [1:0]         dp_addr_q, dp_addr_d;
    logic [2:0]         dp_size_q, dp_size_d;
    logic [COORD_W-1:0] sx1_q, sx1_d, sy1_q, sy1_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               en_q, en_d;
    logic [LW-1:0]      mem_q [DEPTH];

    logic               wr_ok, rd_dp, empty, full, valid;
    logic               push_req, push_acc, pop, flush;
    logic [LW-1:0]      head;
    logic [7:0]         cnt8;
    logic [31:0]        rdata;
    logic               unused_bits;

    assign wr_ok    = dp_vld_q & dp_wr_q & (dp_size_q == 3'b010);
    assign rd_dp    = dp_vld_q & ~dp_wr_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_CNT);
    assign valid    = en_q & ~empty;
    assign pop      = valid & bus.DataReady;
    assign push_req = wr_ok & (dp_addr_q == 2'd1);
    assign flush    = wr_ok & (dp_addr_q == 2'd3) & bus.HWDATA[1];
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign push_acc = push_req & (~full | pop);

    always_comb begin
        dp_vld_d  = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
        dp_wr_d   = bus.HWRITE;
        dp_addr_d = bus.HADDR[3:2];
        dp_size_d = bus.HSIZE;
        sx1_d     = sx1_q;
        sy1_d     = sy1_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        en_d      = en_q;
        if (wr_ok && dp_addr_q == 2'd0) begin
            sx1_d = bus.HWDATA[COORD_W-1:0];
            sy1_d = bus.HWDATA[16 +: COORD_W];
        end
        if (wr_ok && dp_addr_q == 2'd2 && bus.HWDATA[2]) ovf_d = 1'b0;
        if (wr_ok && dp_addr_q == 2'd3) en_d = bus.HWDATA[0];
        if (push_req && full && !pop) ovf_d = 1'b1;
        if (flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_acc) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)      rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_acc, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_vld_q  <= 1'b0;
            dp_wr_q   <= 1'b0;
            dp_addr_q <= '0;
            dp_size_q <= '0;
            sx1_q     <= '0;
            sy1_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            en_q      <= 1'b1;
        end else begin
            dp_vld_q  <= dp_vld_d;
            dp_wr_q   <= dp_wr_d;
            dp_addr_q <= dp_addr_d;
            dp_size_q <= dp_size_d;
            sx1_q     <= sx1_d;
            sy1_q     <= sy1_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            en_q      <= en_d;
        end
    end

    // Storage needs no reset: the outputs are masked to zero while empty.
    always_ff @(posedge HCLK) begin
        if (push_acc)
            mem_q[wr_ptr_q] <= {sx1_q, sy1_q, bus.HWDATA[COORD_W-1:0], bus.HWDATA[16 +: COORD_W]};
    end

    assign cnt8 = 8'(count_q);

    always_comb begin
        rdata = '0;
        if (rd_dp) begin
            case (dp_addr_q)
                2'd0:    rdata = {16'(sy1_q), 16'(sx1_q)};
                2'd2:    rdata = {16'd0, cnt8, 5'd0, ovf_q, full, empty};
                2'd3:    rdata = {31'd0, en_q};
                default: rdata = '0;
            endcase
        end
    end

    assign head          = mem_q[rd_ptr_q];
    assign bus.HRDATA    = rdata;
    assign bus.HREADYOUT = 1'b1;
    assign bus.DataValid = valid;
    assign bus.x1        = empty ? '0 : head[3*COORD_W +: COORD_W];
    assign bus.y1        = empty ? '0 : head[2*COORD_W +: COORD_W];
    assign bus.x2        = empty ? '0 : head[COORD_W +: COORD_W];
    assign bus.y2        = empty ? '0 : head[0 +: COORD_W];

    assign unused_bits = ^{bus.HADDR[31:4], bus.HADDR[1:0], bus.HTRANS[0], bus.HWDATA};
endmodule

// File: tb/tb_ahb_line_fifo.sv
// Scoreboard bench for ahb_line_fifo: bus writes push expected lines, a
// negedge monitor pops and compares every handshake on the line stream.
`timescale 1ns/1ps
module tb_ahb_line_fifo;
    localparam int CW = 9;
    localparam int LW = 4 * CW;

    logic HCLK = 1'b0;
    logic HRESETn;
    always #5 HCLK = ~HCLK;

    ahb_line_fifo_if #(.COORD_W(CW)) bus();
    ahb_line_fifo #(.COORD_W(CW), .DEPTH(8)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_pops  = 0;
    logic [LW-1:0] sb [$];

    function automatic logic [LW-1:0] line_of(input int n);
        logic [CW-1:0] a, b, c, d;
        a = CW'(n * 7 + 1);
        b = CW'(n * 13 + 2);
        c = CW'(n * 29 + 3);
        d = CW'(n * 31 + 4);
        return {a, b, c, d};
    endfunction

    function automatic logic [31:0] pack_xy(input logic [CW-1:0] x, input logic [CW-1:0] y);
        return (32'(y) << 16) | 32'(x);
    endfunction

    // Handshake monitor: a pop completes at the posedge following this negedge.
    always @(negedge HCLK) begin
        if (HRESETn && bus.DataValid && bus.DataReady) begin
            logic [LW-1:0] got, exp;
            got = {bus.x1, bus.y1, bus.x2, bus.y2};
            n_tests++;
            n_pops++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL pop_unexpected: got %h, required no pop", got);
            end else begin
                exp = sb.pop_front();
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL pop_data: got %h, required %h", got, exp);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic ahb_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [2:0] size, input bit dp_rdy);
        logic prev_rdy;
        @(posedge HCLK); #1;
        bus.HSEL = 1'b1; bus.HADDR = {28'd0, addr}; bus.HTRANS = 2'b10;
        bus.HWRITE = 1'b1; bus.HSIZE = size;
        @(posedge HCLK); #1;
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HWDATA = data;
        prev_rdy = bus.DataReady;
        if (dp_rdy) bus.DataReady = 1'b1;
        @(posedge HCLK); #1;
        bus.DataReady = prev_rdy;
    endtask

    task automatic ahb_read(input logic [3:0] addr, output logic [31:0] data);
        @(posedge HCLK); #1;
        bus.HSEL = 1'b1; bus.HADDR = {28'd0, addr}; bus.HTRANS = 2'b10;
        bus.HWRITE = 1'b0; bus.HSIZE = 3'b010;
        @(posedge HCLK); #1;
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
        data = bus.HRDATA;
    endtask

    task automatic push_line(input int n, input bit accept, input bit dp_rdy);
        logic [LW-1:0] l;
        l = line_of(n);
        ahb_write(4'h0, pack_xy(l[4*CW-1 -: CW], l[3*CW-1 -: CW]), 3'b010, 1'b0);
        ahb_write(4'h4, pack_xy(l[2*CW-1 -: CW], l[CW-1:0]), 3'b010, dp_rdy);
        if (accept) sb.push_back(l);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge HCLK);
        #1;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d entries left, required 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        logic [31:0] r;
        HRESETn = 1'b0;
        bus.HSEL = 1'b0; bus.HADDR = '0; bus.HWDATA = '0; bus.HSIZE = 3'b010;
        bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HREADY = 1'b1; bus.DataReady = 1'b0;
        repeat (3) @(posedge HCLK);
        #1;
        n_tests++;
        if ({bus.DataValid, bus.x1, bus.y1, bus.x2, bus.y2, bus.HRDATA, bus.HREADYOUT} !== {1'b0, 36'd0, 32'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b line=%h hrdata=%h hreadyout=%b, required 0/0/0/1",
                     bus.DataValid, {bus.x1, bus.y1, bus.x2, bus.y2}, bus.HRDATA, bus.HREADYOUT);
        end
        HRESETn = 1'b1;
        ahb_read(4'h8, r);
        n_tests++;
        if (r !== 32'h0000_0001) begin n_fail++; $display("FAIL reset_stat: got %h, required 00000001", r); end
        ahb_read(4'hC, r);
        n_tests++;
        if (r !== 32'h0000_0001) begin n_fail++; $display("FAIL reset_ctrl: got %h, required 00000001", r); end
        ahb_read(4'h0, r);
        n_tests++;
        if (r !== 32'h0) begin n_fail++; $display("FAIL reset_x1y1: got %h, required 00000000", r); end
    endtask

    task automatic test_single();
        logic [31:0] r;
        int p0;
        bus.DataReady = 1'b1;
        ahb_write(4'h0, 32'h0014_000A, 3'b010, 1'b0);
        ahb_read(4'h0, r);
        n_tests++;
        if (r !== 32'h0014_000A) begin n_fail++; $display("FAIL single_x1y1_rd: got %h, required 0014000a", r); end
        p0 = n_pops;
        ahb_write(4'h4, 32'h0028_001E, 3'b010, 1'b0);
        sb.push_back({9'd10, 9'd20, 9'd30, 9'd40});
        n_tests++;
        if ({bus.DataValid, bus.x1, bus.y1, bus.x2, bus.y2} !== {1'b1, 9'd10, 9'd20, 9'd30, 9'd40}) begin
            n_fail++;
            $display("FAIL single_head: valid=%b line=%h, required 1/%h", bus.DataValid,
                     {bus.x1, bus.y1, bus.x2, bus.y2}, {9'd10, 9'd20, 9'd30, 9'd40});
        end
        ahb_read(4'h8, r);
        n_tests++;
        if (r !== 32'h0000_0001) begin n_fail++; $display("FAIL single_stat: got %h, required 00000001", r); end
        n_tests++;
        if (n_pops - p0 != 1) begin n_fail++; $display("FAIL single_pops: got %0d, required 1", n_pops - p0); end
    endtask

    task automatic test_overflow();
        logic [31:0] r;
        bus.DataReady = 1'b0;
        for (int i = 1; i <= 8; i++) push_line(i, 1'b1, 1'b0);
        push_line(9, 1'b0, 1'b0);
        ahb_read(4'h8, r);
        n_tests++;
        if (r !== 32'h0000_0806) begin n_fail++; $display("FAIL ovf_stat_full: got %h, required 00000806", r); end
        bus.DataReady = 1'b1;
        drain("ovf");
        bus.DataReady = 1'b0;
        ahb_read(4'h8, r);
        n_tests++;
        if (r !== 32'h0000_0005) begin n_fail++; $display("FAIL ovf_stat_sticky: got %h, required 00000005", r); end
        ahb_write(4'h8, 32'h0000_0004, 3'b010, 1'b0);
        ahb_read(4'h8, r);
        n_tests++;
        if (r !== 32'h0000_0001) begin n_fail++; $display("FAIL ovf_clear: got %h, required 00000001", r); end
    endtask

    task automatic test_full_pop();
        logic [31:0] r;
        bus.DataReady = 1'b0;
        for (int i = 101; i <= 108; i++) push_line(i, 1'b1, 1'b0);
        push_line(109, 1'b1, 1'b1);
        ahb_read(4'h8, r);
        n_tests++;
        if (r !== 32'h0000_0802) begin n_fail++; $display("FAIL fullpop_stat: got %h, required 00000802", r); end
        bus.DataReady = 1'b1;
        drain("fullpop");
        bus.DataReady = 1'b0;
    endtask

    task automatic test_wrap();
        logic [31:0] r;
        bus.DataReady = 1'b0;
        for (int i = 200; i < 205; i++) push_line(i, 1'b1, 1'b0);
        bus.DataReady = 1'b1;
        for (int i = 205; i < 211; i++) push_line(i, 1'b1, 1'b0);
        drain("wrap");
        bus.DataReady = 1'b0;
        ahb_read(4'h8, r);
        n_tests++;
        if (r !== 32'h0000_0001) begin n_fail++; $display("FAIL wrap_stat: got %h, required 00000001", r); end
    endtask

    task automatic test_en_flush();
        logic [31:0] r;
        ahb_write(4'hC, 32'h0, 3'b010, 1'b0);
        bus.DataReady = 1'b1;
        for (int i = 300; i < 303; i++) push_line(i, 1'b0, 1'b0);
        n_tests++;
        if (bus.DataValid !== 1'b0) begin n_fail++; $display("FAIL en_valid: got %b, required 0", bus.DataValid); end
        ahb_read(4'h8, r);
        n_tests++;
        if (r !== 32'h0000_0300) begin n_fail++; $display("FAIL en_stat: got %h, required 00000300", r); end
        ahb_write(4'hC, 32'h3, 3'b010, 1'b0);
        n_tests++;
        if (bus.DataValid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b, required 0", bus.DataValid); end
        ahb_read(4'h8, r);
        n_tests++;
        if (r !== 32'h0000_0001) begin n_fail++; $display("FAIL flush_stat: got %h, required 00000001", r); end
        ahb_read(4'hC, r);
        n_tests++;
        if (r !== 32'h0000_0001) begin n_fail++; $display("FAIL flush_ctrl: got %h, required 00000001", r); end
        bus.DataReady = 1'b0;
    endtask

    task automatic test_size_reset();
        logic [31:0] r;
        bus.DataReady = 1'b0;
        ahb_write(4'h4, 32'h0011_0022, 3'b000, 1'b0);
        ahb_read(4'h8, r);
        n_tests++;
        if (r !== 32'h0000_0001) begin n_fail++; $display("FAIL bytewr_stat: got %h, required 00000001", r); end
        for (int i = 400; i < 405; i++) push_line(i, 1'b1, 1'b0);
        @(posedge HCLK); #1;
        bus.DataReady = 1'b1;
        #2;
        HRESETn = 1'b0;
        #1;
        sb.delete();
        n_tests++;
        if ({bus.DataValid, bus.x1, bus.y1, bus.x2, bus.y2, bus.HRDATA, bus.HREADYOUT} !== {1'b0, 36'd0, 32'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL midreset_outputs: valid=%b line=%h hrdata=%h, required 0/0/0",
                     bus.DataValid, {bus.x1, bus.y1, bus.x2, bus.y2}, bus.HRDATA);
        end
        bus.DataReady = 1'b0;
        repeat (2) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        ahb_read(4'h8, r);
        n_tests++;
        if (r !== 32'h0000_0001) begin n_fail++; $display("FAIL midreset_stat: got %h, required 00000001", r); end
        ahb_read(4'h0, r);
        n_tests++;
        if (r !== 32'h0) begin n_fail++; $display("FAIL midreset_x1y1: got %h, required 00000000", r); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_full_pop();
        test_wrap();
        test_en_flush();
        test_size_reset();
        repeat (3) @(posedge HCLK);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
